// File: rtl/i2s_line_rx_if.sv
// I2S line-input bundle: codec-side serial pins plus the captured sample outputs.
// The codec master drives the pins; the receiver drives samples, strobes and fsm_state.
interface i2s_line_rx_if;
    logic        i_bck;
    logic        i_lrck;
    logic        i_adcdat;
    logic [15:0] o_left;
    logic [15:0] o_right;
    logic        o_valid;
    logic        o_tapein;
    logic        o_frame_err;
    logic [1:0]  fsm_state;

    // o_valid and o_frame_err are single-cycle strobes with no ready/backpressure:
    // a consumer must sample o_left/o_right in the o_valid cycle or any time before
    // the next o_valid, because the pair stays stable until then.
    modport master (
        output i_bck, i_lrck, i_adcdat,
        input  o_left, o_right, o_valid, o_tapein, o_frame_err, fsm_state
    );

    modport slave (
        input  i_bck, i_lrck, i_adcdat,
        output o_left, o_right, o_valid, o_tapein, o_frame_err, fsm_state
    );
endinterface

// File: rtl/i2s_line_rx.sv
// I2S ADC capture: deserialises 16-bit L/R pairs and slices the left channel into a tape bit.
// Optional TAPE_MA_EN: slicer input becomes a 4-tap moving average of the left MSB byte.
module i2s_line_rx #(
    parameter int DATA_BITS   = 16,
    parameter int HYST        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk24,
    input  logic          reset_n,
    i2s_line_rx_if.slave  bus
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bck_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bck_s;
    logic                   lr_s;
    logic                   dat_s;
    logic                   bck_prev;
    logic                   lr_prev;
    logic                   lr_primed;
    logic                   bck_rise;
    logic                   lr_edge;

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            bck_sync <= '0;
            lr_sync  <= '0;
            dat_sync <= '0;
        end else begin
            bck_sync <= {bck_sync[SYNC_STAGES-2:0], bus.i_bck};
            lr_sync  <= {lr_sync[SYNC_STAGES-2:0], bus.i_lrck};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.i_adcdat};
        end
    end

    assign bck_s    = bck_sync[SYNC_STAGES-1];
    assign lr_s     = lr_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign bck_rise = bck_s & ~bck_prev;

    // The first BCK rise after reset only primes lr_prev, so a word already in flight
    // at reset release can never be mistaken for a word start.
    assign lr_edge  = bck_rise & lr_primed & (lr_s != lr_prev);

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            bck_prev  <= 1'b0;
            lr_prev   <= 1'b0;
            lr_primed <= 1'b0;
        end else begin
            bck_prev <= bck_s;
            if (bck_rise) begin
                lr_prev   <= lr_s;
                lr_primed <= 1'b1;
            end
        end
    end

    state_t                 state;
    state_t                 state_n;
    logic                   ch;
    logic                   ch_n;
    logic [CW-1:0]          bitcnt;
    logic [CW-1:0]          bitcnt_n;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_n;
    logic                   latch;
    logic                   frame_err_n;

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ch     <= 1'b0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
        end
    end

    always_comb begin
        state_n     = state;
        ch_n        = ch;
        bitcnt_n    = bitcnt;
        shreg_n     = shreg;
        latch       = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (lr_edge) begin
                    state_n  = SHIFT;
                    ch_n     = lr_s;
                    bitcnt_n = '0;
                    shreg_n  = '0;
                end
            end
            SHIFT: begin
                if (lr_edge) begin
                    // Early word-select edge: drop the partial word, this edge is the new delay slot.
                    frame_err_n = 1'b1;
                    ch_n        = lr_s;
                    bitcnt_n    = '0;
                    shreg_n     = '0;
                end else if (bck_rise) begin
                    shreg_n  = {shreg[DATA_BITS-2:0], dat_s};
                    bitcnt_n = bitcnt + CW'(1);
                    if (bitcnt == CW'(DATA_BITS - 1)) begin
                        latch   = 1'b1;
                        state_n = WAIT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [15:0] word;
    logic [15:0] hold_left;
    logic [15:0] left_r;
    logic [15:0] right_r;
    logic        valid_r;
    logic        frame_err_r;
    logic        tapein_r;

    assign word = shreg_n[DATA_BITS-1 -: 16];

    // The left word waits in hold_left so o_left/o_right only ever change together.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            hold_left   <= '0;
            left_r      <= '0;
            right_r     <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            valid_r     <= latch & ch;
            frame_err_r <= frame_err_n;
            if (latch) begin
                if (ch) begin
                    right_r <= word;
                    left_r  <= hold_left;
                end else begin
                    hold_left <= word;
                end
            end
        end
    end

    logic [7:0] line8;
    logic [7:0] slice_in;

    assign line8 = {~left_r[15], left_r[14:8]};

`ifdef TAPE_MA_EN
    logic [7:0] hist1;
    logic [7:0] hist2;
    logic [7:0] hist3;
    logic [9:0] ma_sum;

    assign ma_sum   = 10'(line8) + 10'(hist1) + 10'(hist2) + 10'(hist3);
    assign slice_in = ma_sum[9:2];

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            hist1 <= 8'd128;
            hist2 <= 8'd128;
            hist3 <= 8'd128;
        end else if (valid_r) begin
            hist1 <= line8;
            hist2 <= hist1;
            hist3 <= hist2;
        end
    end
`else
    assign slice_in = line8;
`endif

    localparam logic [8:0] TH_HI = 9'(128 + HYST);
    localparam logic [8:0] TH_LO = 9'(128 - HYST);

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            tapein_r <= 1'b0;
        end else if (valid_r) begin
            if ({1'b0, slice_in} >= TH_HI) begin
                tapein_r <= 1'b1;
            end else if ({1'b0, slice_in} <= TH_LO) begin
                tapein_r <= 1'b0;
            end
        end
    end

    assign bus.o_left      = left_r;
    assign bus.o_right     = right_r;
    assign bus.o_valid     = valid_r;
    assign bus.o_frame_err = frame_err_r;
    assign bus.o_tapein    = tapein_r;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_i2s_line_rx.sv
// Bench for i2s_line_rx: random I2S slots from a codec-master driver, checked against a
// slot-level reference model (hold/pair queue, frame-error count, hysteresis tape bit).
module tb_i2s_line_rx;
    localparam int SYNC_STAGES = 2;
    localparam int HYST        = 4;

    logic clk24   = 1'b0;
    logic reset_n = 1'b0;

    i2s_line_rx_if bus ();

    i2s_line_rx #(
        .DATA_BITS   (16),
        .HYST        (HYST),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk24   (clk24),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // clock/reset
    always #21 clk24 = ~clk24;

    int cyc = 0;
    always @(posedge clk24) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    // reference model state
    logic [31:0] exp_q[$];
    logic [15:0] m_hold    = '0;
    bit          m_known   = 1'b0;
    bit          m_lr_last = 1'b0;
    bit          m_short   = 1'b0;
    bit          m_tape    = 1'b0;
    int          m_hist[3] = '{128, 128, 128};
    int          exp_err   = 0;
    int          exp_valid = 0;
    int          n_err     = 0;
    int          n_valid   = 0;
    int          t_lsb     = 0;
    int          half      = 4;
    bit          tape_chk  = 1'b0;

    // driver tasks
    task automatic send_bit(input bit lr, input bit d, input bit mark);
        @(negedge clk24);
        bus.i_bck    = 1'b0;
        bus.i_lrck   = lr;
        bus.i_adcdat = d;
        repeat (half) @(negedge clk24);
        bus.i_bck = 1'b1;
        if (mark) t_lsb = cyc;
        repeat (half - 1) @(negedge clk24);
    endtask

    // One word-select slot of nbits BCK periods; bit 0 is the delay slot, then data MSB first.
    task automatic send_slot(input bit lr, input logic [31:0] data, input int nbits);
        bit counted;
        bit d;
        counted = m_known && (lr != m_lr_last);
        if (counted) begin
            if (m_short) exp_err++;
            m_short = (nbits - 1) < 16;
            if (!m_short) begin
                if (!lr) m_hold = data[31:16];
                else begin
                    exp_q.push_back({m_hold, data[31:16]});
                    exp_valid++;
                end
            end
        end else begin
            m_short = 1'b0;
        end
        m_known   = 1'b1;
        m_lr_last = lr;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 || i > 32) d = 1'($urandom_range(0, 1));
            else d = data[32 - i];
            send_bit(lr, d, counted && lr && (i == 16));
        end
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr);
        send_slot(1'b0, l, nl);
        send_slot(1'b1, r, nr);
    endtask

    task automatic do_reset();
        @(negedge clk24);
        reset_n = 1'b0;
        m_known = 1'b0;
        m_short = 1'b0;
        m_hold  = '0;
        m_tape  = 1'b0;
        m_hist  = '{128, 128, 128};
        repeat (3) @(negedge clk24);
        reset_n = 1'b1;
    endtask

    // scoreboard / monitor
    always @(negedge clk24) begin
        logic [31:0] e;
        int line8;
        int val;
        if (tape_chk) begin
            check("tapein", bus.o_tapein, m_tape);
            tape_chk = 1'b0;
        end
        if (reset_n && bus.o_valid) begin
            n_valid++;
            check("latency", 32'((cyc - t_lsb) <= SYNC_STAGES + 3), 1);
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("left", bus.o_left, e[31:16]);
                check("right", bus.o_right, e[15:0]);
                line8 = int'(e[31:24]) ^ 128;
`ifdef TAPE_MA_EN
                val = (line8 + m_hist[0] + m_hist[1] + m_hist[2]) / 4;
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = line8;
`else
                val = line8;
`endif
                if (val >= 128 + HYST) m_tape = 1'b1;
                else if (val <= 128 - HYST) m_tape = 1'b0;
                tape_chk = 1'b1;
            end
        end
        if (reset_n && bus.o_frame_err) n_err++;
    end

    function automatic logic [31:0] rnd32();
        return 32'($urandom);
    endfunction

    initial begin
        bus.i_bck    = 1'b0;
        bus.i_lrck   = 1'b1;
        bus.i_adcdat = 1'b0;
        repeat (5) @(negedge clk24);

        check("rst_left", bus.o_left, 0);
        check("rst_right", bus.o_right, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_tapein", bus.o_tapein, 0);
        check("rst_frame_err", bus.o_frame_err, 0);
        check("rst_state", bus.fsm_state, 0);

        // release with LRCK high mid right word: that partial word must be dropped
        reset_n = 1'b1;
        send_slot(1'b1, rnd32(), 9);

        // nominal 1.5 MHz BCK, fixed pair
        half = 8;
        for (int k = 0; k < 3; k++) frame(32'h1234_0000 | (rnd32() & 32'hFFFF), 32'hABCD_0000 | (rnd32() & 32'hFFFF), 32, 32);
        repeat (20) @(negedge clk24);
        check("no_frame_err_nominal", n_err, 0);
        half = 4;

        // right word truncated after 10 bits, then L=0001 R=FFFF
        frame(rnd32(), rnd32(), 20, 11);
        frame(32'h0001_0000, 32'hFFFF_0000, 32, 32);
        repeat (20) @(negedge clk24);
        check("frame_err_once", n_err, 1);

        // tape slicer byte walk, preceded by a hard low level
        frame(32'h8000_0000, rnd32(), 20, 20);
        foreach (m_hist[i]) m_hist[i] = m_hist[i];
        begin
            logic [7:0] bytes[7] = '{8'h80, 8'h83, 8'h84, 8'h85, 8'h7C, 8'h7B, 8'h7D};
            for (int k = 0; k < 7; k++) frame({bytes[k], 8'(rnd32()), 16'h0}, rnd32(), 20, 20);
        end

        // 24-bit slots: extra bits ignored, following frame aligned
        frame(32'h7FFF_5500, rnd32(), 25, 25);
        frame(rnd32(), rnd32(), 17, 17);

        // reset in the middle of a right word: no strobe, clean restart
        frame(rnd32(), rnd32(), 20, 20);
        send_slot(1'b0, rnd32(), 20);
        send_slot(1'b1, rnd32(), 6);
        do_reset();
        @(negedge clk24);
        check("mid_rst_right", bus.o_right, 0);
        check("mid_rst_state", bus.fsm_state, 0);
        send_slot(1'b1, rnd32(), 10);

        // random slot widths, occasional truncated words
        for (int k = 0; k < 16; k++) begin
            int nl;
            int nr;
            nl = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 16) : $urandom_range(17, 33);
            nr = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 16) : $urandom_range(17, 33);
            frame(rnd32(), rnd32(), nl, nr);
        end
        frame(rnd32(), rnd32(), 20, 20);
        repeat (50) @(negedge clk24);

        // final report
        check("exp_q_drained", exp_q.size(), 0);
        check("valid_count", n_valid, exp_valid);
        check("frame_err_count", n_err, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
